// File: rtl/conv_pkg.sv
// Shared helpers for the convolution window front end: sizing functions and
// the window element bit-offset helper.
package conv_pkg;

  localparam int DEF_D_WIDTH     = 8;
  localparam int DEF_D_CHANNELS  = 3;
  localparam int DEF_FILTER_SIZE = 5;
  localparam int PIXEL_W         = DEF_D_CHANNELS * DEF_D_WIDTH;
  localparam int WINDOW_W        = DEF_FILTER_SIZE * DEF_FILTER_SIZE * PIXEL_W;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Element (i,j) of an f x f window, row-major from the top-left corner.
  function automatic int win_offset(input int i, input int j, input int f, input int pixel_w);
    return (i * f + j) * pixel_w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-stage delay line of WIDTH-bit words, advanced only when en is high.
// Circular RAM with one pointer: the slot about to be overwritten is the oldest word.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WIDTH = PIXEL_W,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  assign q = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-scan to FILTER_SIZE x FILTER_SIZE sliding window with stride,
// input gating, frame-end flag and asynchronous reset.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int D_CHANNELS   = 3,
  parameter int FILTER_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 32,
  parameter int STRIDE       = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 clk_en,
  input  logic                                                 in_valid,
  input  logic [D_CHANNELS*D_WIDTH-1:0]                        input_data,
  output logic [FILTER_SIZE*FILTER_SIZE*D_CHANNELS*D_WIDTH-1:0] window_data,
  output logic                                                 valid,
  output logic                                                 frame_done
);

  localparam int F   = FILTER_SIZE;
  localparam int W   = IMAGE_WIDTH;
  localparam int H   = IMAGE_HEIGHT;
  localparam int S   = STRIDE;
  localparam int PW  = D_CHANNELS * D_WIDTH;
  localparam int CW  = (clog2(W) < 1) ? 1 : clog2(W);
  localparam int RW  = (clog2(H) < 1) ? 1 : clog2(H);
  localparam int PHW = clog2(S + 1);

  if (F < 2 || F > W || F > H || S < 1) begin : g_bad_params
    $error("conv_window_buffer: illegal FILTER_SIZE/STRIDE for the image size");
  end

  typedef struct packed {
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [PHW-1:0] row_ph;
    logic [PHW-1:0] col_ph;
  } pos_t;

  pos_t pos, pos_nxt;
  logic accept, hit, last_col, last_row;

  logic [F-2:0][PW-1:0]        lb_d, lb_q;
  logic [F-1:0][PW-1:0]        tap;
  logic [F-1:0][F-1:0][PW-1:0] win;

  assign accept   = clk_en & in_valid;
  assign last_col = (pos.col == CW'(W - 1));
  assign last_row = (pos.row == RW'(H - 1));
  // Phases stay at zero until the axis reaches F-1, so zero phase means "on the stride grid".
  assign hit      = (pos.row >= RW'(F - 1)) && (pos.col >= CW'(F - 1)) &&
                    (pos.row_ph == '0) && (pos.col_ph == '0);

  // Line buffers chain: buffer k holds the row k+1 rows above the incoming one.
  for (genvar k = 0; k < F - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_d[k] = input_data;
    end else begin : g_next
      assign lb_d[k] = lb_q[k-1];
    end
    conv_line_buffer #(.WIDTH(PW), .DEPTH(W)) u_lb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .d     (lb_d[k]),
      .q     (lb_q[k])
    );
  end

  for (genvar i = 0; i < F; i++) begin : g_tap
    if (i == F - 1) begin : g_bottom
      assign tap[i] = input_data;
    end else begin : g_upper
      assign tap[i] = lb_q[F-2-i];
    end
    for (genvar j = 0; j < F; j++) begin : g_out
      assign window_data[win_offset(i, j, F, PW) +: PW] = win[i][j];
    end
  end

  always_comb begin
    pos_nxt = pos;
    if (accept) begin
      if (last_col) begin
        pos_nxt.col    = '0;
        pos_nxt.col_ph = '0;
        if (last_row) begin
          pos_nxt.row    = '0;
          pos_nxt.row_ph = '0;
        end else begin
          pos_nxt.row = pos.row + RW'(1);
          if (pos.row >= RW'(F - 1))
            pos_nxt.row_ph = (pos.row_ph == PHW'(S - 1)) ? '0 : pos.row_ph + PHW'(1);
        end
      end else begin
        pos_nxt.col = pos.col + CW'(1);
        if (pos.col >= CW'(F - 1))
          pos_nxt.col_ph = (pos.col_ph == PHW'(S - 1)) ? '0 : pos.col_ph + PHW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= '0;
    else        pos <= pos_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      for (int i = 0; i < F; i++) begin
        for (int j = 0; j < F - 1; j++) win[i][j] <= win[i][j+1];
        win[i][F-1] <= tap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      valid      <= in_valid & hit;
      frame_done <= in_valid & last_col & last_row;
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: two configurations checked cycle by cycle
// against an image-array reference model, driven from a scenario table.
module tb_conv_window_buffer;

  localparam int F  = 3;
  localparam int PW = 24;
  localparam int WW = F * F * PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [1:0]            ce, iv, vo, fo;
  logic [1:0][PW-1:0]    din;
  logic [1:0][WW-1:0]    wd;

  conv_window_buffer #(.D_WIDTH(8), .D_CHANNELS(3), .FILTER_SIZE(3),
                       .IMAGE_WIDTH(6), .IMAGE_HEIGHT(4), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(ce[0]), .in_valid(iv[0]), .input_data(din[0]),
    .window_data(wd[0]), .valid(vo[0]), .frame_done(fo[0]));

  conv_window_buffer #(.D_WIDTH(8), .D_CHANNELS(3), .FILTER_SIZE(3),
                       .IMAGE_WIDTH(7), .IMAGE_HEIGHT(5), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(ce[1]), .in_valid(iv[1]), .input_data(din[1]),
    .window_data(wd[1]), .valid(vo[1]), .frame_done(fo[1]));

  int wt[2] = '{6, 7};
  int ht[2] = '{4, 5};
  int st[2] = '{1, 2};

  // Reference model: the frame as a plain image array plus a pixel index.
  int           img [2][8][8];
  int           mn  [2];
  int           cv  [2];
  bit           ev  [2];
  bit           ef  [2];
  logic [WW-1:0] ew [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int d; int nfr; int pct; int hold;
    int exp_wins; int exp_fds; int exp_first;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [PW-1:0] pix(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mupd(input int k);
    int r, c;
    if (ce[k]) begin
      if (iv[k]) begin
        r = mn[k] / wt[k];
        c = mn[k] % wt[k];
        img[k][r][c] = cv[k];
        ev[k] = (r >= F-1) && (c >= F-1) && ((r-F+1) % st[k] == 0) && ((c-F+1) % st[k] == 0);
        ef[k] = (mn[k] == wt[k]*ht[k] - 1);
        if (ev[k])
          for (int i = 0; i < F; i++)
            for (int j = 0; j < F; j++)
              ew[k][(i*F+j)*PW +: PW] = pix(img[k][r-F+1+i][c-F+1+j]);
        mn[k] = (mn[k] + 1) % (wt[k]*ht[k]);
      end else begin
        ev[k] = 1'b0;
        ef[k] = 1'b0;
      end
    end
  endtask

  task automatic step(input int d, input bit en, input bit ivv, input int v);
    for (int k = 0; k < 2; k++) begin ce[k] = 1'b1; iv[k] = 1'b0; end
    ce[d] = en; iv[d] = ivv; din[d] = pix(v); cv[d] = v;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      mupd(k);
      chk("valid", WW'(vo[k]), WW'(ev[k]));
      chk("frame_done", WW'(fo[k]), WW'(ef[k]));
      if (ev[k]) chk("window", wd[k], ew[k]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin ce[k] = 1'b1; iv[k] = 1'b0; end
    #1;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; ev[k] = 1'b0; ef[k] = 1'b0; ew[k] = '0;
      chk("rst_valid", WW'(vo[k]), '0);
      chk("rst_frame_done", WW'(fo[k]), '0);
      chk("rst_window", wd[k], '0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int d, input int nfr, input int pct, input int hold, input int base,
                     output int wins, output int fds, output int first);
    int acc, tot, cyc, fr, p;
    bit ivv, held;
    acc = 0; cyc = 0; held = 1'b0;
    tot = nfr * wt[d] * ht[d];
    wins = 0; fds = 0; first = -1;
    while (acc < tot && cyc < 4000) begin
      ivv = (pct >= 100) || ($urandom_range(99) < pct);
      fr  = acc / (wt[d]*ht[d]);
      p   = acc % (wt[d]*ht[d]);
      step(d, 1'b1, ivv, base + fr*100 + p);
      if (ivv) acc++;
      cyc++;
      if (vo[d]) begin
        wins++;
        if (first < 0) first = acc;
      end
      if (fo[d]) fds++;
      if (hold > 0 && !held && first >= 0) begin
        held = 1'b1;
        repeat (hold) step(d, 1'b0, 1'b1, 77);
      end
    end
    chk("pixels_accepted", WW'(acc), WW'(tot));
  endtask

  initial begin
    int w, f, fi;
    tbl[0] = '{0, 1, 100, 0,  8, 1, 15};  // S=1 full-rate frame
    tbl[1] = '{1, 1, 100, 0,  6, 1, 17};  // S=2, 7x5
    tbl[2] = '{0, 1,  50, 0,  8, 1, 15};  // gated input
    tbl[3] = '{0, 1, 100, 5,  8, 1, 15};  // clk_en freeze after first window
    tbl[4] = '{0, 2, 100, 0, 16, 2, 15};  // back-to-back frames

    rst_n = 1'b0;
    ce = '1; iv = '0; din = '0;
    for (int k = 0; k < 2; k++) cv[k] = 0;

    for (int t = 0; t < 5; t++) begin
      do_reset();
      run(tbl[t].d, tbl[t].nfr, tbl[t].pct, tbl[t].hold, 0, w, f, fi);
      chk("window_count", WW'(w), WW'(tbl[t].exp_wins));
      chk("frame_done_count", WW'(f), WW'(tbl[t].exp_fds));
      chk("first_valid_pixel", WW'(fi), WW'(tbl[t].exp_first));
    end

    // Abort a frame after 10 pixels; stale rows must never appear.
    do_reset();
    for (int p = 0; p < 10; p++) step(0, 1'b1, 1'b1, 200 + p);
    do_reset();
    run(0, 1, 100, 0, 0, w, f, fi);
    chk("post_reset_windows", WW'(w), WW'(8));
    chk("post_reset_first", WW'(fi), WW'(15));
    chk("post_reset_frame_done", WW'(f), WW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
Sliding-window front end for the next generation of convolutional layers. It accepts a raster-scan pixel stream, one pixel per accepted cycle. It emits a full FILTER_SIZE x FILTER_SIZE x D_CHANNELS window for every valid, strided output position.
- Generalises the current layer front end: separate image width and height, any stride >= 1, input-side gating (in_valid), explicit frame-end signalling and asynchronous reset.
- The MAC array downstream consumes window_data directly.

Parameters:
D_WIDTH, 8, bits per channel sample
D_CHANNELS, 3, channels per input pixel
FILTER_SIZE, 5, window side F; must satisfy 2 <= F <= IMAGE_WIDTH and F <= IMAGE_HEIGHT
IMAGE_WIDTH, 64, pixels per row W
IMAGE_HEIGHT, 32, rows per frame H
STRIDE, 1, output step S in both axes; S >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global enable; low freezes all state and outputs
in_valid  in  1  input_data holds a pixel this cycle
input_data  in  D_CHANNELS*D_WIDTH  pixel, channel 0 in LSBs
window_data  out  F*F*D_CHANNELS*D_WIDTH  window; element (i,j) (i=row from top, j=col from left) at bit offset (i*F+j)*D_CHANNELS*D_WIDTH
valid  out  1  window_data is a new output window (one-cycle pulse per window)
frame_done  out  1  asserted with the final pixel's cycle output; marks end of frame

Behaviour:
- Reset (rst_n low, asynchronous): col=0, row=0, valid=0, frame_done=0, window_data=0. Line-buffer storage is not reset.
- Accept = clk_en & in_valid. Pixels are never dropped; there is no backpressure to the source.
- clk_en low: no state changes. valid, frame_done and window_data hold their last values.
- clk_en high, in_valid low: valid and frame_done go 0 at the edge; window_data holds; counters hold.
- On accept of the pixel at (row r, col c):
  - the pixel is shifted into column F-1 of the bottom window row;
  - rows 0..F-2 take the matching pixels from F-1 line buffers of W-pixel depth;
  - the line buffers advance by one.
- Window condition: r >= F-1, c >= F-1, (r-(F-1)) mod S == 0 and (c-(F-1)) mod S == 0.
  - Track the modulo with per-axis phase counters; no dividers.
- Latency: valid=1 on the cycle after the accepting edge when the condition holds. window_data then shows pixels (r-F+1..r, c-F+1..c).
- Counters: col wraps W-1 -> 0 with row+1. At (H-1, W-1), row and col both go to 0 and frame_done=1 in the same output cycle as that pixel's valid (if any).
- Windows never span a row wrap: the condition requires c >= F-1.
- Windows per frame = ((W-F)/S+1) * ((H-F)/S+1), integer division. Trailing rows/cols not reached by the stride are consumed silently.
- Back-to-back frames need no gap. The first pixel of frame N+1 may be accepted on the cycle after frame N's last pixel.
- Stale line-buffer data from an aborted frame is never visible: no window is produced until F-1 rows of the current frame are stored.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Illegal parameters (F > W, F > H, S == 0, F < 2) cause an elaboration-time $error.

Decomposition:
- Shared package conv_pkg:
  - clog2 function;
  - localparams PIXEL_W = D_CHANNELS*D_WIDTH and WINDOW_W = F*F*PIXEL_W;
  - window-index helper function for the bit offset.
- One sub-module, conv_line_buffer (parameters WIDTH, DEPTH, ports clk, rst_n, en, d, q): a DEPTH-stage delay line.
  - Instantiated F-1 times in a generate loop.
  - Inferred as shift register / RAM with a pointer.

Test Plan:
1. W=6, H=4, F=3, S=1, pixel value = r*6+c, in_valid always 1 -> first valid follows the 15th pixel (value 14). Window row0 = 0,1,2; row2 = 12,13,14. Exactly 8 windows; frame_done on the 24th output cycle.
2. W=7, H=5, F=3, S=2 -> 6 windows, at bottom-right pixels (2,2),(2,4),(2,6),(4,2),(4,4),(4,6). First window top-left = 0, last bottom-right = 34.
3. Config 1 with in_valid toggling pseudo-randomly (50%) -> the same 8 windows in the same order. valid never asserts in a cycle following in_valid=0.
4. Config 1 with clk_en low for 5 cycles right after the first valid -> valid, window_data and frame_done hold for 5 cycles. The remaining 7 windows are unchanged.
5. Config 1 with rst_n pulsed low after 10 pixels, then a full frame -> all outputs 0 during reset. First valid follows the 15th post-reset pixel with window values 0..14 and no stale data.
6. Two back-to-back frames (frame 2 values offset by 100) -> 16 windows, 2 frame_done pulses. First window of frame 2 contains only values >= 100.
